// File: rtl/dff_response_checker_pkg.sv
// Shared types for the DFF response checker.
// Holds the run-control state encoding.
package chk_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/dff_response_checker_delay.sv
// Expected-value delay line for the response checker.
// Output is the input sampled DEPTH rising edges earlier.
module sample_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sample,
    output logic [WIDTH-1:0] delayed
);

    logic [WIDTH-1:0] taps [DEPTH];

    // Shift every clock regardless of checker state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps[i] <= '0;
            end
        end else begin
            taps[0] <= sample;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign delayed = taps[DEPTH-1];

endmodule

// File: rtl/dff_response_checker.sv
// Self-checking responder for register-style DUTs.
// Compares dut_q against dut_d delayed LATENCY clocks over a run.
module dff_response_checker
    import chk_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 1,
    parameter int CYC_W   = 16,
    parameter int ERR_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CYC_W-1:0] run_len,
    input  logic [WIDTH-1:0] dut_d,
    input  logic [WIDTH-1:0] dut_q,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [CYC_W-1:0] first_err_cycle
);

    localparam int FILL_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LATENCY - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    state_t state;
    state_t state_next;

    logic [CYC_W-1:0]  len_q;
    logic [CYC_W-1:0]  idx;
    logic [FILL_W-1:0] fill_cnt;
    logic [WIDTH-1:0]  expected;

    logic             accept;
    logic             cmp_en;
    logic             mismatch;
    logic             enter_done;
    logic [ERR_W-1:0] err_next;

    sample_delay_line #(
        .WIDTH (WIDTH),
        .DEPTH (LATENCY)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .sample  (dut_d),
        .delayed (expected)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        cmp_en     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                if (fill_cnt == FILL_LAST) begin
                    state_next = (len_q == '0) ? DONE : CHECK;
                end
            end
            CHECK: begin
                cmp_en = 1'b1;
                if (idx == len_q - CYC_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Compare result and saturating error increment for this edge
    always_comb begin
        mismatch   = cmp_en && (dut_q != expected);
        enter_done = (state_next == DONE) && (state != DONE);
        err_next   = err_count;
        if (mismatch && (err_count != ERR_MAX)) begin
            err_next = err_count + ERR_W'(1);
        end
    end

    // Run length latch and fill / compare-index counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q    <= '0;
            idx      <= '0;
            fill_cnt <= '0;
        end else begin
            if (accept) begin
                len_q    <= run_len;
                idx      <= '0;
                fill_cnt <= '0;
            end else begin
                if (state == FILL) begin
                    fill_cnt <= fill_cnt + FILL_W'(1);
                end
                if (cmp_en) begin
                    idx <= idx + CYC_W'(1);
                end
            end
        end
    end

    // Error count and first-failure capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_cycle <= '0;
        end else if (accept) begin
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_cycle <= '0;
        end else begin
            err_count <= err_next;
            if (mismatch && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_cycle <= idx;
            end
        end
    end

    // Pass flag: cleared on start, settled as the run enters DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass <= 1'b0;
        end else if (accept) begin
            pass <= 1'b0;
        end else if (enter_done) begin
            pass <= (err_next == '0);
        end
    end

    assign busy = (state == FILL) || (state == CHECK);
    assign done = (state == DONE);

endmodule

// File: tb/tb_dff_response_checker.sv
// Scoreboard bench for dff_response_checker.
// A DFF model acts as DUT; faults are injected on its output.
module tb_dff_response_checker;

    localparam int W  = 4;
    localparam int CW = 16;
    localparam int EW = 8;

    typedef struct {
        bit pass;
        int err;
        int fev;
        int fec;
    } exp_t;

    typedef struct {
        string name;
        bit    busy;
        bit    done;
        bit    pass;
        int    err;
        int    fev;
        int    fec;
    } snap_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] run_len = '0;
    logic [W-1:0]  dut_d = '0;
    logic [W-1:0]  dut_q;
    logic [W-1:0]  q_r = '0;
    logic [W-1:0]  inj = '0;
    logic          busy;
    logic          done;
    logic          pass;
    logic [EW-1:0] err_count;
    logic          first_err_valid;
    logic [CW-1:0] first_err_cycle;

    exp_t  sb_q[$];
    snap_t snap_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    end_req = 0;
    bit    fin = 0;

    logic [W-1:0] pat [8] = '{4'h1, 4'h0, 4'hF, 4'hA,
                              4'h5, 4'h3, 4'hC, 4'h7};

    always #5 clk = ~clk;

    always @(posedge clk) q_r <= dut_d;
    assign dut_q = q_r ^ inj;

    dff_response_checker #(
        .WIDTH   (W),
        .LATENCY (1),
        .CYC_W   (CW),
        .ERR_W   (EW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .run_len         (run_len),
        .dut_d           (dut_d),
        .dut_q           (dut_q),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_cycle (first_err_cycle)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: snapshot checks and scoreboard pops on done
    initial begin
        int watch;
        snap_t s;
        exp_t e;
        watch = 0;
        forever begin
            @(negedge clk);
            while (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                chk({s.name, ".busy"}, int'(busy), int'(s.busy));
                chk({s.name, ".done"}, int'(done), int'(s.done));
                chk({s.name, ".pass"}, int'(pass), int'(s.pass));
                chk({s.name, ".err"}, int'(err_count), s.err);
                chk({s.name, ".fev"}, int'(first_err_valid), s.fev);
                chk({s.name, ".fec"}, int'(first_err_cycle), s.fec);
            end
            if (done) begin
                watch = 0;
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb.pass", int'(pass), int'(e.pass));
                    chk("sb.err", int'(err_count), e.err);
                    chk("sb.fev", int'(first_err_valid), e.fev);
                    chk("sb.fec", int'(first_err_cycle), e.fec);
                end
            end else if (sb_q.size() > 0) begin
                watch++;
                if (watch > 1000) begin
                    chk("done_timeout", 1, 0);
                    void'(sb_q.pop_front());
                    watch = 0;
                end
            end
            if (end_req && !fin) begin
                chk("sb_drained", sb_q.size(), 0);
                fin = 1;
            end
        end
    end

    function automatic snap_t mk(input string n, input bit b,
                                 input bit d, input bit p,
                                 input int er, input int fv,
                                 input int fc);
        snap_t s;
        s.name = n; s.busy = b; s.done = d; s.pass = p;
        s.err = er; s.fev = fv; s.fec = fc;
        return s;
    endfunction

    task automatic run(input string name, input int len,
                       input int b1, input int b2,
                       input bit stuck, input logic [W-1:0] flip,
                       input int poke_k, input int abort_k,
                       input exp_t e);
        if (abort_k < 0) sb_q.push_back(e);
        run_len = CW'(len);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k <= len; k++) begin
            dut_d = pat[k % 8];
            if (stuck) inj = '1;
            else if (k - 1 == b1 || k - 1 == b2) inj = flip;
            else inj = '0;
            start = (k == poke_k);
            if (k == 0)
                snap_q.push_back(mk({name, ".fill"}, 1, 0, 0, 0, 0, 0));
            if (k == abort_k) begin
                rst = 1'b1;
                #1;
                snap_q.push_back(mk({name, ".abort"}, 0, 0, 0, 0, 0, 0));
                @(posedge clk);
                #1;
                rst = 1'b0;
                inj = '0;
                start = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        inj = '0;
        snap_q.push_back(mk({name, ".done"}, 0, 1, e.pass,
                            e.err, e.fev, e.fec));
        @(posedge clk);
        #1;
        snap_q.push_back(mk({name, ".hold"}, 0, 0, e.pass,
                            e.err, e.fev, e.fec));
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t ok, e2, e2b, e2c, e4, ex;
        ok  = '{pass: 1, err: 0,   fev: 0, fec: 0};
        e2  = '{pass: 0, err: 1,   fev: 1, fec: 3};
        e2b = '{pass: 0, err: 2,   fev: 1, fec: 7};
        e2c = '{pass: 0, err: 1,   fev: 1, fec: 19};
        e4  = '{pass: 0, err: 255, fev: 1, fec: 0};
        ex  = '{pass: 0, err: 0,   fev: 0, fec: 0};

        repeat (2) @(posedge clk);
        #1;
        snap_q.push_back(mk("reset", 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run("t1_clean", 20, -100, -100, 0, '0, -1, -1, ok);
        run("t2_idx3", 20, 3, -100, 0, 4'b0100, -1, -1, e2);
        run("t2_two", 20, 7, 19, 0, 4'b1111, -1, -1, e2b);
        run("t2_last", 20, 19, -100, 0, 4'b0001, -1, -1, e2c);
        run("t3_len0", 0, -100, -100, 0, '0, -1, -1, ok);
        run("t4_sat", 300, -100, -100, 1, '0, -1, -1, e4);
        run("t5_poke", 20, -100, -100, 0, '0, 5, -1, ok);
        run("t6_abort", 50, -100, -100, 1, '0, -1, 10, ex);
        repeat (5) @(posedge clk);
        #1;
        run("t6_rerun", 20, -100, -100, 0, '0, -1, -1, ok);

        repeat (5) @(posedge clk);
        end_req = 1;
        for (int i = 0; i < 20 && !fin; i++) @(posedge clk);
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
